// File: rtl/crc_pkg.sv
// Shared definitions for the CRC sequencing master: responder register map,
// CTRL field layout, stream word format and sequencer states.
package crc_pkg;

    localparam logic [31:0] CRC_DATA_OFS  = 32'h0000_0000;
    localparam logic [31:0] CRC_GPOLY_OFS = 32'h0000_0004;
    localparam logic [31:0] CRC_CTRL_OFS  = 32'h0000_0008;

    // WAS selects whether a DATA write loads the seed (1) or feeds the CRC (0)
    localparam logic [31:0] CTRL_WAS_MASK = 32'h0200_0000;

    typedef struct packed {
        logic [1:0]  tot;
        logic [1:0]  totr;
        logic        rsvd27;
        logic        fxor;
        logic        was;
        logic        tcrc;
        logic [23:0] rsvd;
    } ctrl_t;

    typedef struct packed {
        logic        last;
        logic [31:0] dat;
    } word_t;

    typedef enum logic [2:0] {
        IDLE,
        W_CTRL_SEED,
        W_POLY,
        W_SEED,
        W_CTRL_RUN,
        STREAM,
        RD_RES,
        DONE
    } state_t;

endpackage

// File: rtl/crc_seq_master_if.sv
// Single-cycle register bus between the CRC sequencer (master) and the CRC responder (slave).
interface crc_seq_master_if;

    logic        Sel;
    logic        RW;
    logic [31:0] addr;
    logic [31:0] data_wr;
    logic [31:0] data_rd;

    modport master (output Sel, RW, addr, data_wr, input data_rd);
    modport slave  (input Sel, RW, addr, data_wr, output data_rd);

endinterface

// File: rtl/crc_word_fifo.sv
// Purpose: small synchronous FIFO holding stream words for the sequencer.
// Latency: a pushed entry is poppable from the cycle after the push (no bypass).
// Backpressure: full blocks pushes unless a pop happens in the same cycle; pops on empty are ignored.
module crc_word_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign pop_dat = mem[rd_ptr];

    // DEPTH is a power of two, so pointer overflow is the wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/crc_seq_master.sv
// Purpose: programs a CRC responder (CTRL/GPOLY/seed), streams buffered words into DATA, reads back the result.
// Latency: 7 cycles start-to-done with one word preloaded; one bus cycle per state, registered outputs.
// Backpressure: in_ready = !full of the word FIFO; an empty FIFO in STREAM stalls the bus indefinitely.
module crc_seq_master
    import crc_pkg::*;
#(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] CRC_BASE   = 32'h4003_2000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [31:0]             cfg_ctrl,
    input  logic [31:0]             cfg_poly,
    input  logic [31:0]             cfg_seed,
    input  logic [31:0]             cfg_expect,
    input  logic                    start,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [31:0]             in_data,
    input  logic                    in_last,
    crc_seq_master_if.master        bus,
    output logic                    busy,
    output logic                    done,
    output logic                    match,
    output logic [31:0]             result,
    output logic [15:0]             word_cnt
);

    localparam logic [31:0] ADDR_DATA  = CRC_BASE + CRC_DATA_OFS;
    localparam logic [31:0] ADDR_GPOLY = CRC_BASE + CRC_GPOLY_OFS;
    localparam logic [31:0] ADDR_CTRL  = CRC_BASE + CRC_CTRL_OFS;

    state_t      state;
    ctrl_t       ctrl_q;
    logic [31:0] poly_q;
    logic [31:0] seed_q;
    logic [31:0] expect_q;
    logic        sel_q;
    logic        rw_q;
    logic [31:0] addr_q;
    logic [31:0] wdat_q;
    logic        last_sent;
    word_t       push_word;
    word_t       pop_word;
    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_pop;

    assign push_word = {in_last, in_data};
    assign in_ready  = !fifo_full;

    crc_word_fifo #(
        .WIDTH ($bits(word_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (in_valid && in_ready),
        .push_dat (push_word),
        .pop      (fifo_pop),
        .pop_dat  (pop_word),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Bus outputs are registered one edge ahead, so each word is popped on entry to its bus cycle
    assign fifo_pop = !fifo_empty && ((state == W_CTRL_RUN) || (state == STREAM && !last_sent));

    assign bus.Sel     = sel_q;
    assign bus.RW      = rw_q;
    assign bus.addr    = addr_q;
    assign bus.data_wr = wdat_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ctrl_q    <= '0;
            poly_q    <= '0;
            seed_q    <= '0;
            expect_q  <= '0;
            sel_q     <= 1'b0;
            rw_q      <= 1'b0;
            addr_q    <= '0;
            wdat_q    <= '0;
            last_sent <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            match     <= 1'b0;
            result    <= '0;
            word_cnt  <= '0;
        end else begin
            sel_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        ctrl_q    <= cfg_ctrl;
                        poly_q    <= cfg_poly;
                        seed_q    <= cfg_seed;
                        expect_q  <= cfg_expect;
                        word_cnt  <= '0;
                        last_sent <= 1'b0;
                        busy      <= 1'b1;
                        sel_q     <= 1'b1;
                        rw_q      <= 1'b1;
                        addr_q    <= ADDR_CTRL;
                        wdat_q    <= cfg_ctrl | CTRL_WAS_MASK;
                        state     <= W_CTRL_SEED;
                    end
                end
                W_CTRL_SEED: begin
                    sel_q  <= 1'b1;
                    rw_q   <= 1'b1;
                    addr_q <= ADDR_GPOLY;
                    wdat_q <= poly_q;
                    state  <= W_POLY;
                end
                W_POLY: begin
                    sel_q  <= 1'b1;
                    rw_q   <= 1'b1;
                    addr_q <= ADDR_DATA;
                    wdat_q <= seed_q;
                    state  <= W_SEED;
                end
                W_SEED: begin
                    sel_q  <= 1'b1;
                    rw_q   <= 1'b1;
                    addr_q <= ADDR_CTRL;
                    wdat_q <= 32'(ctrl_q) & ~CTRL_WAS_MASK;
                    state  <= W_CTRL_RUN;
                end
                W_CTRL_RUN: begin
                    state <= STREAM;
                end
                STREAM: begin
                    if (last_sent) begin
                        sel_q  <= 1'b1;
                        rw_q   <= 1'b0;
                        addr_q <= ADDR_DATA;
                        state  <= RD_RES;
                    end
                end
                RD_RES: begin
                    result <= bus.data_rd;
                    match  <= (bus.data_rd == expect_q);
                    done   <= 1'b1;
                    state  <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (fifo_pop) begin
                sel_q     <= 1'b1;
                rw_q      <= 1'b1;
                addr_q    <= ADDR_DATA;
                wdat_q    <= pop_word.dat;
                word_cnt  <= word_cnt + 16'd1;
                last_sent <= pop_word.last;
            end
        end
    end

endmodule

// File: tb/tb_crc_seq_master.sv
// Randomized bench for crc_seq_master: expected bus transaction list and result built from the register-programming rules.
module tb_crc_seq_master;

    localparam logic [31:0] BASE = 32'h4003_2000;
    localparam logic [31:0] WAS  = 32'h0200_0000;

    logic        clk;
    logic        rst_n;
    logic [31:0] cfg_ctrl, cfg_poly, cfg_seed, cfg_expect;
    logic        start;
    logic        in_valid, in_ready, in_last;
    logic [31:0] in_data;
    logic        busy, done, match;
    logic [31:0] result;
    logic [15:0] word_cnt;
    logic [31:0] rd_value;

    int n_checks = 0;
    int n_errors = 0;
    int hold_last = 0;

    logic [32:0] src_q[$];
    logic [31:0] exp_words[$];
    logic [64:0] bus_log[$];

    crc_seq_master_if bus();
    assign bus.data_rd = rd_value;

    crc_seq_master #(.FIFO_DEPTH(4), .CRC_BASE(BASE)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_ctrl(cfg_ctrl), .cfg_poly(cfg_poly), .cfg_seed(cfg_seed), .cfg_expect(cfg_expect),
        .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .bus(bus),
        .busy(busy), .done(done), .match(match), .result(result), .word_cnt(word_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [64:0] got, input logic [64:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Producer: offers the head word each cycle; a held last word is withheld while hold_last > 0
    initial begin
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
        forever begin
            @(negedge clk);
            if (src_q.size() > 0 && src_q[0][32] && hold_last > 0) begin
                hold_last--;
                in_valid = 1'b0;
            end else if (src_q.size() > 0) begin
                in_valid = 1'b1;
                in_last  = src_q[0][32];
                in_data  = src_q[0][31:0];
                if (in_ready) void'(src_q.pop_front());
            end else begin
                in_valid = 1'b0;
            end
        end
    end

    // Bus monitor: every cycle with Sel=1 is one transaction
    initial forever begin
        @(negedge clk);
        if (bus.Sel === 1'b1) bus_log.push_back({bus.RW, bus.addr, bus.data_wr});
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic queue_word(input logic [31:0] w, input bit last);
        src_q.push_back({last, w});
        exp_words.push_back(w);
    endtask

    task automatic queue_rand(input int n);
        for (int i = 0; i < n; i++) queue_word($urandom, (i == n - 1));
    endtask

    task automatic check_reset_outputs(input string pfx);
        chk({pfx, "_sel"}, bus.Sel, 1'b0);
        chk({pfx, "_rw"}, bus.RW, 1'b0);
        chk({pfx, "_addr"}, bus.addr, 32'h0);
        chk({pfx, "_wdat"}, bus.data_wr, 32'h0);
        chk({pfx, "_busy"}, busy, 1'b0);
        chk({pfx, "_done"}, done, 1'b0);
        chk({pfx, "_match"}, match, 1'b0);
        chk({pfx, "_result"}, result, 32'h0);
        chk({pfx, "_wcnt"}, word_cnt, 16'h0);
        chk({pfx, "_in_ready"}, in_ready, 1'b1);
    endtask

    // One full run over the words queued in exp_words; compares the complete bus trace and the outcome
    task automatic run(input logic [31:0] ctrl, input logic [31:0] poly, input logic [31:0] seed,
                       input logic [31:0] expv, input logic [31:0] rdv, input bit dup, input int hold,
                       output int lat, output int idle);
        logic [64:0] exp_log[$];
        int n;
        n = exp_words.size();
        exp_log.push_back({1'b1, BASE + 32'h8, ctrl | WAS});
        exp_log.push_back({1'b1, BASE + 32'h4, poly});
        exp_log.push_back({1'b1, BASE, seed});
        exp_log.push_back({1'b1, BASE + 32'h8, ctrl & ~WAS});
        foreach (exp_words[i]) exp_log.push_back({1'b1, BASE, exp_words[i]});
        exp_log.push_back({1'b0, BASE, exp_words[n - 1]});

        cfg_ctrl = ctrl; cfg_poly = poly; cfg_seed = seed; cfg_expect = expv;
        rd_value = rdv;
        @(negedge clk);
        bus_log.delete();
        start = 1'b1;
        hold_last = hold;
        lat = 0;
        idle = 0;
        while (lat < 400) begin
            @(negedge clk);
            start = (dup && lat == 2);
            lat++;
            if (busy && !bus.Sel && !done) idle++;
            if (done) break;
        end
        start = 1'b0;
        chk("run_done_seen", done, 1'b1);
        chk("run_result", result, rdv);
        chk("run_match", match, (rdv == expv));
        chk("run_wcnt", word_cnt, 16'(n));
        chk("run_busy_in_done", busy, 1'b1);
        @(negedge clk);
        chk("run_done_pulse", done, 1'b0);
        chk("run_busy_end", busy, 1'b0);
        chk("bus_len", bus_log.size(), exp_log.size());
        for (int i = 0; i < exp_log.size() && i < bus_log.size(); i++)
            chk($sformatf("bus_txn%0d", i), bus_log[i], exp_log[i]);
        exp_words.delete();
    endtask

    initial begin
        int lat, idle;
        rst_n = 1'b0;
        start = 1'b0;
        cfg_ctrl = '0; cfg_poly = '0; cfg_seed = '0; cfg_expect = '0;
        rd_value = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        @(negedge clk);

        // Config sequence and minimum latency with one preloaded word
        queue_word($urandom, 1'b1);
        repeat (3) @(negedge clk);
        run(32'h0100_0000, 32'h04C1_1DB7, 32'hFFFF_FFFF, 32'h0, $urandom, 1'b0, 0, lat, idle);
        chk("latency", lat, 7);

        // Zero CRC run
        queue_word(32'h0, 1'b1);
        repeat (3) @(negedge clk);
        run(32'h0, 32'h1021, 32'h0, 32'h0, 32'h0, 1'b0, 0, lat, idle);

        // Mismatch with a start pulse while busy
        queue_word(32'h0, 1'b1);
        repeat (3) @(negedge clk);
        run(32'h0, 32'h1021, 32'h0, 32'h1234, 32'h0, 1'b1, 0, lat, idle);

        // Back-pressure: six words against a four-deep buffer while idle
        queue_rand(6);
        repeat (10) @(negedge clk);
        chk("bp_in_ready", in_ready, 1'b0);
        chk("bp_pending", src_q.size(), 2);
        run($urandom, $urandom, $urandom, 32'h5, 32'h5, 1'b0, 0, lat, idle);

        // Stall: last word withheld well past the first stream write
        hold_last = 16;
        queue_word($urandom, 1'b0);
        queue_word($urandom, 1'b1);
        repeat (3) @(negedge clk);
        run($urandom, $urandom, $urandom, 32'h7, 32'h9, 1'b0, 16, lat, idle);
        chk("stall_idle_ge10", (idle >= 10), 1'b1);

        // Reset in the middle of STREAM
        hold_last = 30;
        queue_rand(3);
        cfg_ctrl = $urandom; cfg_poly = $urandom; cfg_seed = $urandom;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        chk("mid_busy", busy, 1'b1);
        rst_n = 1'b0;
        src_q.delete();
        exp_words.delete();
        hold_last = 0;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        bus_log.delete();
        repeat (5) @(negedge clk);
        chk("post_rst_quiet", bus_log.size(), 0);
        queue_rand(2);
        run($urandom, $urandom, $urandom, 32'h1, 32'h1, 1'b0, 0, lat, idle);

        // Randomized runs
        for (int r = 0; r < 8; r++) begin
            logic [31:0] rv;
            rv = $urandom;
            queue_rand($urandom_range(1, 6));
            repeat ($urandom_range(0, 8)) @(negedge clk);
            run($urandom, $urandom, $urandom, ($urandom_range(0, 1) != 0) ? rv : $urandom, rv,
                ($urandom_range(0, 1) != 0), $urandom_range(0, 4), lat, idle);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
